// File: rtl/pwm_sequencer_pkg.sv
// Shared types and width helpers for the PWM compare-value sequencer.
// Optional interrupt support is enabled with the PWM_SEQUENCER_IRQ_EN macro.
package pwm_sequencer_pkg;

    // Default geometry of the sequencer
    localparam int unsigned DEF_OUTPUTS      = 4;
    localparam int unsigned DEF_WIDTH        = 16;
    localparam int unsigned DEF_DEPTH        = 8;
    localparam int unsigned DEF_REPEAT_WIDTH = 8;

    // cfg_field value that addresses the repeat count instead of a channel
    localparam int unsigned FIELD_REPEAT = DEF_OUTPUTS;

    // Width helpers for the default geometry
    localparam int unsigned INDEX_BITS  = $clog2(DEF_DEPTH);
    localparam int unsigned LENGTH_BITS = $clog2(DEF_DEPTH) + 1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10
    } state_e;

    // Bits needed to address one of depth table entries
    function automatic int unsigned index_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Bits needed to hold a sequence length of 0..depth
    function automatic int unsigned length_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Bits needed to select a channel or the repeat field
    function automatic int unsigned field_bits(input int unsigned outputs);
        return $clog2(outputs + 1);
    endfunction

endpackage

// File: rtl/pwm_seq_table.sv
// Duty-cycle table for the PWM sequencer: per entry, OUTPUTS compare words
// plus a repeat count. One synchronous write port, one combinational read port.
module pwm_seq_table
    import pwm_sequencer_pkg::*;
#(
    parameter int unsigned OUTPUTS      = DEF_OUTPUTS,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned REPEAT_WIDTH = DEF_REPEAT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_index_i,
    input  logic [$clog2(OUTPUTS+1)-1:0] wr_field_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_index_i,
    output logic [OUTPUTS*WIDTH-1:0]   rd_cmp_o,
    output logic [REPEAT_WIDTH-1:0]    rd_rpt_o
);

    localparam int unsigned FB = field_bits(OUTPUTS);

    logic [WIDTH-1:0]        cmp_q [DEPTH][OUTPUTS];
    logic [REPEAT_WIDTH-1:0] rpt_q [DEPTH];

    // Table storage: field values above OUTPUTS match nothing and are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                for (int c = 0; c < int'(OUTPUTS); c++) begin
                    cmp_q[e][c] <= '0;
                end
                rpt_q[e] <= '0;
            end
        end else if (wr_en_i) begin
            for (int c = 0; c < int'(OUTPUTS); c++) begin
                if (wr_field_i == FB'(c)) begin
                    cmp_q[wr_index_i][c] <= wr_data_i;
                end
            end
            if (wr_field_i == FB'(OUTPUTS)) begin
                rpt_q[wr_index_i] <= wr_data_i[REPEAT_WIDTH-1:0];
            end
        end
    end

    // Read port: the entry the sequencer will load next
    always_comb begin
        rd_cmp_o = '0;
        for (int c = 0; c < int'(OUTPUTS); c++) begin
            rd_cmp_o[c*WIDTH +: WIDTH] = cmp_q[rd_index_i][c];
        end
        rd_rpt_o = rpt_q[rd_index_i];
    end

endmodule

// File: rtl/pwm_sequencer.sv
// PWM compare-value sequencer: steps the compare outputs through a programmed
// table, advancing only on PWM period boundaries. One-shot or looping.
// Define PWM_SEQUENCER_IRQ_EN to add the sticky irq / irq_clear ports.
module pwm_sequencer
    import pwm_sequencer_pkg::*;
#(
    parameter int unsigned OUTPUTS      = DEF_OUTPUTS,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned REPEAT_WIDTH = DEF_REPEAT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(DEPTH)-1:0]     cfg_index,
    input  logic [$clog2(OUTPUTS+1)-1:0] cfg_field,
    input  logic [WIDTH-1:0]             cfg_data,
    input  logic [$clog2(DEPTH):0]       seq_length,
    input  logic                         seq_loop,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         period_end,
    output logic [OUTPUTS*WIDTH-1:0]     compare_value,
    output logic                         compare_update,
    output logic                         busy,
    output logic                         done,
`ifdef PWM_SEQUENCER_IRQ_EN
    output logic                         irq,
    input  logic                         irq_clear,
`endif
    output logic [$clog2(DEPTH)-1:0]     current_index
);

    localparam int unsigned IB = index_bits(DEPTH);
    localparam int unsigned LB = length_bits(DEPTH);

    state_e                   state_q, state_d;
    logic [IB-1:0]            idx_q, idx_d;
    logic [REPEAT_WIDTH-1:0]  rpt_q, rpt_d;
    logic [OUTPUTS*WIDTH-1:0] cmp_q, cmp_d;
    logic                     upd_q, upd_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [LB-1:0]            eff_len_s;
    logic                     advance_s;
    logic [IB-1:0]            rd_idx_s;
    logic [OUTPUTS*WIDTH-1:0] rd_cmp_s;
    logic [REPEAT_WIDTH-1:0]  rd_rpt_s;

    pwm_seq_table #(
        .OUTPUTS      (OUTPUTS),
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .REPEAT_WIDTH (REPEAT_WIDTH)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (cfg_we),
        .wr_index_i (cfg_index),
        .wr_field_i (cfg_field),
        .wr_data_i  (cfg_data),
        .rd_index_i (rd_idx_s),
        .rd_cmp_o   (rd_cmp_s),
        .rd_rpt_o   (rd_rpt_s)
    );

    // Clamp the requested length and decide whether another entry follows;
    // a length shrunk below index+1 makes the next advance wrap or finish
    always_comb begin
        eff_len_s = seq_length;
        if (seq_length > LB'(DEPTH)) begin
            eff_len_s = LB'(DEPTH);
        end else begin
            eff_len_s = seq_length;
        end
        advance_s = (({1'b0, idx_q} + LB'(1)) < eff_len_s);
        rd_idx_s  = '0;
        if ((state_q == RUN) && advance_s) begin
            rd_idx_s = idx_q + IB'(1);
        end else begin
            rd_idx_s = '0;
        end
    end

    // FSM next state, entry loading and repeat countdown; stop overrides all
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        cmp_d   = cmp_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (eff_len_s != '0)) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARMED: begin
                    if (period_end) begin
                        state_d = RUN;
                        idx_d   = '0;
                        rpt_d   = rd_rpt_s;
                        cmp_d   = rd_cmp_s;
                        upd_d   = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end
                RUN: begin
                    if (!period_end) begin
                        state_d = RUN;
                    end else if (rpt_q != '0) begin
                        rpt_d = rpt_q - REPEAT_WIDTH'(1);
                    end else if (advance_s || seq_loop) begin
                        idx_d = rd_idx_s;
                        rpt_d = rd_rpt_s;
                        cmp_d = rd_cmp_s;
                        upd_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rpt_q   <= '0;
            cmp_q   <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rpt_q   <= rpt_d;
            cmp_q   <= cmp_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PWM_SEQUENCER_IRQ_EN
    logic irq_q, irq_d;
    logic irq_set_s;

    // Sticky interrupt: set on completion or on a loop wrap (load of entry 0
    // from RUN); a set beats a simultaneous clear
    always_comb begin
        irq_set_s = done_d || (upd_d && (state_q == RUN) && (rd_idx_s == '0));
        if (irq_set_s) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign compare_value  = cmp_q;
    assign compare_update = upd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign current_index  = idx_q;

endmodule
